// File: rtl/led_pkg.sv
// Shared encodings for the LED pattern generator: mode codes and ping-pong direction.
package led_pkg;

   typedef logic [1:0] mode_t;

   localparam mode_t MODE_ROT_L = 2'd0;
   localparam mode_t MODE_ROT_R = 2'd1;
   localparam mode_t MODE_PING  = 2'd2;
   localparam mode_t MODE_BLINK = 2'd3;

   localparam logic DIR_UP = 1'b0;
   localparam logic DIR_DN = 1'b1;

endpackage

// File: rtl/led_prescaler.sv
// Programmable prescaler: counts enabled clocks and emits a tick when the count
// reaches the period, then restarts from zero. A synchronous clear restarts the
// interval regardless of enable, so a newly applied period starts from a full count.
module led_prescaler #(
   parameter int CNT_W = 25
) (
   input  logic             clk_ss,
   input  logic             rst,
   input  logic             i_en,
   input  logic             i_clr,
   input  logic [CNT_W-1:0] i_period,
   output logic             o_tick
);

   logic [CNT_W-1:0] r_cnt;

   // Tick only while running, so a frozen counter can never produce a step.
   assign o_tick = i_en && (r_cnt == i_period);

   // Interval counter: clear has priority, otherwise count or wrap while enabled.
   always_ff @(posedge clk_ss or posedge rst) begin
      if (rst)
         r_cnt <= '0;
      else if (i_clr)
         r_cnt <= '0;
      else if (i_en)
         r_cnt <= o_tick ? '0 : r_cnt + CNT_W'(1);
   end

endmodule

// File: rtl/led_pattern_ctrl.sv
// Parametrised LED pattern generator. Holds the shadow/pending configuration,
// the active mode and period, the LED pattern register, the ping-pong direction
// and the one-hot self-repair for the shifting modes.
module led_pattern_ctrl
   import led_pkg::*;
#(
   parameter int NUM_LEDS       = 4,
   parameter int CNT_W          = 25,
   parameter int DEFAULT_PERIOD = 999
) (
   input  logic                clk_ss,
   input  logic                rst,
   input  logic                en,
   input  logic                cfg_load,
   input  logic [1:0]          cfg_mode,
   input  logic [CNT_W-1:0]    cfg_period,
   output logic [NUM_LEDS-1:0] leds,
   output logic                step_pulse
);

   localparam logic [CNT_W-1:0]    DEF_PERIOD = CNT_W'(DEFAULT_PERIOD);
   localparam logic [NUM_LEDS-1:0] SEED_ONE   = NUM_LEDS'(1);
   localparam logic [NUM_LEDS-1:0] SEED_ALL   = '1;

   mode_t               r_mode;
   mode_t               r_sh_mode;
   logic [CNT_W-1:0]    r_period;
   logic [CNT_W-1:0]    r_sh_period;
   logic                r_pending;
   logic [NUM_LEDS-1:0] r_leds;
   logic                r_dir;
   logic                r_step;

   logic                w_tick;
   logic                w_apply;
   logic                w_repair;
   logic [NUM_LEDS-1:0] w_leds_nxt;
   logic                w_dir_nxt;
   logic [NUM_LEDS-1:0] w_shl;
   logic [NUM_LEDS-1:0] w_shr;

   // Pending config lands on the next tick, or immediately when paused.
   assign w_apply  = r_pending && (w_tick || !en);
   // Shifting modes must always show exactly one LED; blink is exempt.
   assign w_repair = (r_mode != MODE_BLINK) && !$onehot(r_leds);
   assign w_shl    = r_leds << 1;
   assign w_shr    = r_leds >> 1;

   led_prescaler #(.CNT_W(CNT_W)) u_presc (
      .clk_ss   (clk_ss),
      .rst      (rst),
      .i_en     (en),
      .i_clr    (w_apply),
      .i_period (r_period),
      .o_tick   (w_tick)
   );

   // Next pattern: apply seed beats repair, repair beats a normal step.
   always_comb begin
      w_leds_nxt = r_leds;
      w_dir_nxt  = r_dir;
      if (w_apply) begin
         w_leds_nxt = (r_sh_mode == MODE_BLINK) ? SEED_ALL : SEED_ONE;
         w_dir_nxt  = DIR_UP;
      end else if (w_repair) begin
         w_leds_nxt = SEED_ONE;
         w_dir_nxt  = DIR_UP;
      end else if (w_tick) begin
         case (r_mode)
            MODE_ROT_L: w_leds_nxt = w_shl | (r_leds >> (NUM_LEDS-1));
            MODE_ROT_R: w_leds_nxt = w_shr | (r_leds << (NUM_LEDS-1));
            MODE_PING: begin
               // A single LED has nowhere to bounce; it just stays lit.
               if (NUM_LEDS == 1) begin
                  w_leds_nxt = r_leds;
                  w_dir_nxt  = DIR_UP;
               end else if (r_dir == DIR_UP) begin
                  if (r_leds[NUM_LEDS-1]) begin
                     w_leds_nxt = w_shr;
                     w_dir_nxt  = DIR_DN;
                  end else begin
                     w_leds_nxt = w_shl;
                  end
               end else begin
                  if (r_leds[0]) begin
                     w_leds_nxt = w_shl;
                     w_dir_nxt  = DIR_UP;
                  end else begin
                     w_leds_nxt = w_shr;
                  end
               end
            end
            default: w_leds_nxt = ~r_leds;
         endcase
      end
   end

   // Pattern, direction and step strobe registers.
   always_ff @(posedge clk_ss or posedge rst) begin
      if (rst) begin
         r_leds <= SEED_ONE;
         r_dir  <= DIR_UP;
         r_step <= 1'b0;
      end else begin
         r_leds <= w_leds_nxt;
         r_dir  <= w_dir_nxt;
         r_step <= w_tick;
      end
   end

   // Config: apply the shadow, then a same-cycle load re-arms with new values.
   always_ff @(posedge clk_ss or posedge rst) begin
      if (rst) begin
         r_mode      <= MODE_ROT_L;
         r_period    <= DEF_PERIOD;
         r_sh_mode   <= MODE_ROT_L;
         r_sh_period <= DEF_PERIOD;
         r_pending   <= 1'b0;
      end else begin
         if (w_apply) begin
            r_mode    <= r_sh_mode;
            r_period  <= r_sh_period;
            r_pending <= 1'b0;
         end
         if (cfg_load) begin
            r_sh_mode   <= cfg_mode;
            r_sh_period <= cfg_period;
            r_pending   <= 1'b1;
         end
      end
   end

   assign leds       = r_leds;
   assign step_pulse = r_step;

endmodule

// File: tb/tb_led_pattern_ctrl.sv
// Directed bench for led_pattern_ctrl with NUM_LEDS=4: walks each mode, a
// mid-pattern reconfigure, pause/resume, self-repair, period 0 and reset.
module tb_led_pattern_ctrl;
   import led_pkg::*;

   localparam int N  = 4;
   localparam int CW = 25;

   logic          clk_ss = 1'b0;
   logic          rst;
   logic          en;
   logic          cfg_load;
   logic [1:0]    cfg_mode;
   logic [CW-1:0] cfg_period;
   logic [N-1:0]  leds;
   logic          step_pulse;

   int n_chk = 0;
   int n_err = 0;

   always #5 clk_ss = ~clk_ss;

   led_pattern_ctrl #(
      .NUM_LEDS       (N),
      .CNT_W          (CW),
      .DEFAULT_PERIOD (999)
   ) dut (
      .clk_ss     (clk_ss),
      .rst        (rst),
      .en         (en),
      .cfg_load   (cfg_load),
      .cfg_mode   (cfg_mode),
      .cfg_period (cfg_period),
      .leds       (leds),
      .step_pulse (step_pulse)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic clk1();
      @(posedge clk_ss);
      #1;
   endtask

   // With cnt at 0 and period 3: three quiet clocks, then a step on the fourth.
   task automatic step4(input logic [N-1:0] exp, input string tag);
      for (int i = 0; i < 3; i++) begin
         clk1();
         chk({tag, "_idle"}, 32'(step_pulse), 32'd0);
      end
      clk1();
      chk({tag, "_pulse"}, 32'(step_pulse), 32'd1);
      chk({tag, "_leds"}, 32'(leds), 32'(exp));
   endtask

   // Load while paused so the shadow applies on the following clock.
   task automatic load_cfg(input logic [1:0] m, input logic [CW-1:0] p,
                           input logic [N-1:0] seed, input string tag);
      en         = 1'b0;
      cfg_mode   = m;
      cfg_period = p;
      cfg_load   = 1'b1;
      clk1();
      cfg_load   = 1'b0;
      clk1();
      chk({tag, "_seed"}, 32'(leds), 32'(seed));
      en = 1'b1;
   endtask

   initial begin
      int seen;
      rst        = 1'b1;
      en         = 1'b0;
      cfg_load   = 1'b0;
      cfg_mode   = 2'd0;
      cfg_period = '0;
      #2;
      chk("rst_leds", 32'(leds), 32'h1);
      chk("rst_step", 32'(step_pulse), 32'd0);
      clk1();
      rst = 1'b0;

      // Rotate left
      load_cfg(MODE_ROT_L, 3, 4'b0001, "rotl");
      step4(4'b0010, "rotl1");
      step4(4'b0100, "rotl2");
      step4(4'b1000, "rotl3");
      step4(4'b0001, "rotl4");
      clk1();
      chk("pulse_width", 32'(step_pulse), 32'd0);

      // Rotate right
      load_cfg(MODE_ROT_R, 3, 4'b0001, "rotr");
      step4(4'b1000, "rotr1");
      step4(4'b0100, "rotr2");
      step4(4'b0010, "rotr3");
      step4(4'b0001, "rotr4");
      step4(4'b1000, "rotr5");

      // Ping-pong
      load_cfg(MODE_PING, 3, 4'b0001, "ping");
      step4(4'b0010, "ping1");
      step4(4'b0100, "ping2");
      step4(4'b1000, "ping3");
      step4(4'b0100, "ping4");
      step4(4'b0010, "ping5");
      step4(4'b0001, "ping6");
      step4(4'b0010, "ping7");

      // Blink, then reconfigure mid-pattern while running
      load_cfg(MODE_BLINK, 3, 4'b1111, "blink");
      step4(4'b0000, "blink1");
      step4(4'b1111, "blink2");
      cfg_mode   = MODE_ROT_L;
      cfg_period = 3;
      cfg_load   = 1'b1;
      clk1();
      cfg_load   = 1'b0;
      chk("midload_wait", 32'(leds), 32'hF);
      clk1();
      clk1();
      clk1();
      chk("midload_pulse", 32'(step_pulse), 32'd1);
      chk("midload_seed", 32'(leds), 32'h1);
      step4(4'b0010, "after_apply");

      // Pause mid-interval
      clk1();
      clk1();
      en   = 1'b0;
      seen = 0;
      for (int i = 0; i < 10; i++) begin
         clk1();
         if (step_pulse) seen++;
      end
      chk("frz_nostep", 32'(seen), 32'd0);
      chk("frz_leds", 32'(leds), 32'h2);
      en = 1'b1;
      clk1();
      chk("resume_idle", 32'(step_pulse), 32'd0);
      clk1();
      chk("resume_pulse", 32'(step_pulse), 32'd1);
      chk("resume_leds", 32'(leds), 32'h4);
      step4(4'b1000, "rotl5");
      step4(4'b0001, "rotl6");

      // Self-repair of a corrupted pattern
      force dut.r_leds = 4'b0110;
      #1;
      release dut.r_leds;
      clk1();
      chk("repair_0110", 32'(leds), 32'h1);
      chk("repair_nostep", 32'(step_pulse), 32'd0);
      force dut.r_leds = 4'b0000;
      #1;
      release dut.r_leds;
      clk1();
      chk("repair_0000", 32'(leds), 32'h1);

      // Period 0: a step every clock
      load_cfg(MODE_ROT_L, 0, 4'b0001, "p0");
      clk1();
      chk("p0_s1", 32'({step_pulse, leds}), 32'h12);
      clk1();
      chk("p0_s2", 32'({step_pulse, leds}), 32'h14);
      clk1();
      chk("p0_s3", 32'({step_pulse, leds}), 32'h18);
      clk1();
      chk("p0_s4", 32'({step_pulse, leds}), 32'h11);

      // Reset in the middle of a ping-pong descent
      load_cfg(MODE_PING, 3, 4'b0001, "ping_b");
      step4(4'b0010, "pingb1");
      step4(4'b0100, "pingb2");
      step4(4'b1000, "pingb3");
      step4(4'b0100, "pingb4");
      clk1();
      rst = 1'b1;
      #1;
      chk("arst_leds", 32'(leds), 32'h1);
      chk("arst_step", 32'(step_pulse), 32'd0);
      clk1();
      rst  = 1'b0;
      seen = 0;
      for (int i = 0; i < 999; i++) begin
         clk1();
         if (step_pulse) seen++;
      end
      chk("def_noearly", 32'(seen), 32'd0);
      chk("def_hold", 32'(leds), 32'h1);
      clk1();
      chk("def_pulse", 32'(step_pulse), 32'd1);
      chk("def_leds", 32'(leds), 32'h2);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_err);
      $finish;
   end

endmodule
